uart_tx_word: RTL

Parametrised UART transmitter that serialises a full WORD_W-bit word as a back-to-back burst of 8-bit UART frames, least-significant byte first. Each frame has configurable stop bits and optional even parity, and the word is driven on a single TX line. It sits between the core's result/debug path and the board TX pin. It replaces the single-byte transmitter wherever wide results must leave the chip.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_gen.sv | 49 ++++
 rtl/uart_tx_word.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions for the word transmitter and the
//               companion receiver. It holds the frame state encoding, the
//               byte width and the idle line level, plus an even-parity
//               helper.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int   UART_BYTE_W    = 8;
    localparam logic UART_LINE_IDLE = 1'b1;

    // Frame sequencer states. The encoding is explicit so that the values
    // stay stable across builds, including builds without parity.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Even parity: XOR of all data bits. The frame's total count of ones,
    // including the parity bit, is then even.
    function automatic logic even_parity(input logic [UART_BYTE_W-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period timer. It counts 0..CLKS_PER_BIT-1 while enabled
//               and then wraps to 0. o_Bit_Tick is high for the single cycle
//               in which the count sits at CLKS_PER_BIT-1, which is the last
//               cycle of the current bit period.
// Ports       : i_Clock    - system clock, rising edge
//               i_Rst_n    - asynchronous active-low reset
//               i_Clear    - synchronous clear of the count (takes priority)
//               i_Enable   - count enable
//               o_Bit_Tick - end-of-bit strobe
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Bit_Tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_count <= '0;
        end else if (i_Clear) begin
            r_count <= '0;
        end else if (i_Enable) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_Bit_Tick = i_Enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_word.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_word
// Description : UART transmitter for a WORD_W-bit word. The word goes out as
//               a gap-free burst of 8-bit frames, least-significant byte
//               first. Each frame is a start bit, 8 data bits (LSB first),
//               an optional even-parity bit and STOP_BITS stop bits.
// Build macro : UART_TX_PARITY_EN - when defined, every frame carries an
//               even-parity bit after the data bits.
// Ports       : i_Clock        - system clock, rising edge
//               i_Rst_n        - asynchronous active-low reset
//               i_Tx_DV        - word valid, sampled only while ready
//               i_Tx_Word      - word to send, captured on acceptance
//               o_Tx_Ready     - a word can be accepted
//               o_Tx_Active    - a word is being transmitted
//               o_Tx_Serial    - UART line, idle high
//               o_Tx_Byte_Done - one-cycle pulse at the end of each frame
//               o_Tx_Done      - one-cycle pulse after the last frame
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int WORD_W       = 256,
    parameter int STOP_BITS    = 1
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Tx_DV,
    input  logic [WORD_W-1:0] i_Tx_Word,
    output logic              o_Tx_Ready,
    output logic              o_Tx_Active,
    output logic              o_Tx_Serial,
    output logic              o_Tx_Byte_Done,
    output logic              o_Tx_Done
);

    localparam int NUM_BYTES = WORD_W / UART_BYTE_W;
    localparam int BIDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [BIDX_W-1:0] c_LAST_BYTE = BIDX_W'(NUM_BYTES - 1);
    localparam logic [2:0]        c_LAST_BIT  = 3'd7;
    // The stop-bit counter only ever needs to tell the first stop bit from
    // the second, so a single bit is enough.
    localparam logic              c_LAST_STOP = (STOP_BITS == 2);

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_word: CLKS_PER_BIT must be at least 2");
        end
        if ((WORD_W < UART_BYTE_W) || ((WORD_W % UART_BYTE_W) != 0)) begin : g_bad_word_w
            $error("uart_tx_word: WORD_W must be a non-zero multiple of 8");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
            $error("uart_tx_word: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    uart_state_t             r_state;
    logic [WORD_W-1:0]       r_shift;
    logic [BIDX_W-1:0]       r_byte_idx;
    logic [2:0]              r_bit_idx;
    logic                    r_stop_cnt;
    logic                    r_serial;
    logic                    r_active;
    logic                    r_ready;
    logic                    r_byte_done;
    logic                    r_done;

    logic                    w_bit_tick;
    logic                    w_timer_clear;
    logic                    w_timer_en;
    logic [UART_BYTE_W-1:0]  w_cur_byte;

    // The byte on the wire is always the low byte of the shift register;
    // the register shifts right by one byte between frames.
    assign w_cur_byte = r_shift[UART_BYTE_W-1:0];

    // The bit timer is held at zero while idle, so the first bit period of
    // a word starts cleanly on the acceptance edge. It then runs without a
    // break until the word is finished, which keeps frames back to back.
    assign w_timer_clear = (r_state == IDLE);
    assign w_timer_en    = (r_state != IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .i_Clock    (i_Clock),
        .i_Rst_n    (i_Rst_n),
        .i_Clear    (w_timer_clear),
        .i_Enable   (w_timer_en),
        .o_Bit_Tick (w_bit_tick)
    );

    // ------------------------------------------------------------------------
    // Frame sequencer. The line level is registered and updated on the same
    // edge as the state, so the line always matches the state it is in.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_bit_idx   <= '0;
            r_stop_cnt  <= 1'b0;
            r_serial    <= UART_LINE_IDLE;
            r_active    <= 1'b0;
            r_ready     <= 1'b1;
            r_byte_done <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_Tx_DV) begin
                        r_shift    <= i_Tx_Word;
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_serial   <= 1'b0;
                        r_active   <= 1'b1;
                        r_ready    <= 1'b0;
                        r_state    <= START;
                    end
                end

                START: begin
                    if (w_bit_tick) begin
                        r_bit_idx <= '0;
                        r_serial  <= w_cur_byte[0];
                        r_state   <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            r_serial <= even_parity(w_cur_byte);
                            r_state  <= PARITY;
`else
                            r_serial   <= UART_LINE_IDLE;
                            r_stop_cnt <= 1'b0;
                            r_state    <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_serial  <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_tick) begin
                        r_serial   <= UART_LINE_IDLE;
                        r_stop_cnt <= 1'b0;
                        r_state    <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_tick) begin
                        if (r_stop_cnt != c_LAST_STOP) begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end else begin
                            r_byte_done <= 1'b1;
                            if (r_byte_idx != c_LAST_BYTE) begin
                                // Next byte starts on this very edge: no idle
                                // gap between frames of one word.
                                r_byte_idx <= r_byte_idx + 1'b1;
                                r_shift    <= r_shift >> UART_BYTE_W;
                                r_serial   <= 1'b0;
                                r_state    <= START;
                            end else begin
                                r_done   <= 1'b1;
                                r_active <= 1'b0;
                                r_ready  <= 1'b1;
                                r_serial <= UART_LINE_IDLE;
                                r_state  <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    r_serial <= UART_LINE_IDLE;
                    r_active <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Ready     = r_ready;
    assign o_Tx_Active    = r_active;
    assign o_Tx_Serial    = r_serial;
    assign o_Tx_Byte_Done = r_byte_done;
    assign o_Tx_Done      = r_done;

endmodule
`default_nettype wire
